// File: rtl/instr_fetch_issue.sv
// Instruction fetch and field-issue stage.
// Owns the PC, fetches one instruction at a time from instruction memory,
// decodes the fields the control decoder needs and holds them while stalled.
module instr_fetch_issue #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rvalid,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_offset,
    output logic [XLEN-1:0] pc,
    output logic            instr_valid,
    output logic [2:0]      tipo,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ISSUE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            capture;
    logic            advance;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            unused_rdata;

    // Opcode bits [3:2] carry no information this stage uses.
    assign unused_rdata = ^imem_rdata[3:2];
    assign imem_addr    = pc;

    // State register; reset also drops any response still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the handshake/issue strobes.
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                imem_req  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    advance   = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Immediate extraction and legality check on the incoming word.
    always_comb begin
        dec_imm = '0;
        case (imem_rdata[6:4])
            3'b000, 3'b001:
                dec_imm = {{(XLEN-12){imem_rdata[31]}}, imem_rdata[31:20]};
            3'b010:
                dec_imm = {{(XLEN-12){imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
            3'b110:
                dec_imm = {{(XLEN-13){imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                           imem_rdata[30:25], imem_rdata[11:8], 1'b0};
            default: dec_imm = '0;
        endcase
        dec_illegal = (imem_rdata[1:0] != 2'b11) ||
                      !(imem_rdata[6:4] inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110});
    end

    // PC update and field registers; fields change only on a captured response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            tipo    <= '0;
            funct3  <= '0;
            funct7  <= '0;
            rd      <= '0;
            rs1     <= '0;
            rs2     <= '0;
            imm     <= '0;
            illegal <= 1'b0;
        end else begin
            if (capture) begin
                tipo    <= imem_rdata[6:4];
                funct3  <= imem_rdata[14:12];
                funct7  <= imem_rdata[31:25];
                rd      <= imem_rdata[11:7];
                rs1     <= imem_rdata[19:15];
                rs2     <= imem_rdata[24:20];
                imm     <= dec_imm;
                illegal <= dec_illegal;
            end
            if (advance) begin
                pc <= pc + (branch_taken ? branch_offset : XLEN'(PC_STEP));
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: hand-computed vector table,
// directed corner sequences, and random fetches checked against a decode model.
module tb_instr_fetch_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic [31:0] pc;
    logic        instr_valid;
    logic [2:0]  tipo;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;

    instr_fetch_issue #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
        .pc(pc), .instr_valid(instr_valid),
        .tipo(tipo), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  tipo;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    int unsigned npass  = 0;
    int unsigned ntotal = 0;
    logic [31:0] mpc;
    vec_t        tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Decode rules written directly from the instruction-format definitions.
    function automatic vec_t model(input logic [31:0] w);
        vec_t v;
        int s;
        int b;
        v.w    = w;
        v.tipo = 3'((w >> 4) % 8);
        v.f3   = 3'((w >> 12) % 8);
        v.f7   = 7'(w >> 25);
        v.rd   = 5'((w >> 7) % 32);
        v.rs1  = 5'((w >> 15) % 32);
        v.rs2  = 5'((w >> 20) % 32);
        s = int'(w);
        case (v.tipo)
            3'd0, 3'd1: v.imm = 32'(s >>> 20);
            3'd2:       v.imm = 32'((s >>> 25) * 32 + int'((w >> 7) % 32));
            3'd6: begin
                b = int'((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                         (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1));
                if (b >= 4096) b -= 8192;
                v.imm = 32'(b);
            end
            default:    v.imm = 32'd0;
        endcase
        v.ill = (w % 4 != 3) || !(v.tipo inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6});
        return v;
    endfunction

    task automatic chk_fields(input vec_t e);
        chk("instr_valid", 32'(instr_valid), 32'd1);
        chk("tipo",    32'(tipo),    32'(e.tipo));
        chk("funct3",  32'(funct3),  32'(e.f3));
        chk("funct7",  32'(funct7),  32'(e.f7));
        chk("rd",      32'(rd),      32'(e.rd));
        chk("rs1",     32'(rs1),     32'(e.rs1));
        chk("rs2",     32'(rs2),     32'(e.rs2));
        chk("imm",     imm,          e.imm);
        chk("illegal", 32'(illegal), 32'(e.ill));
        chk("pc_issue", pc, mpc);
    endtask

    // Bounded wait for the next request pulse, then check its address.
    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
        chk("req_addr", imem_addr, mpc);
    endtask

    // One full fetch: response after dly WAIT cycles, held stall_cyc cycles, then released.
    task automatic do_fetch(input vec_t e, input int dly, input int stall_cyc,
                            input logic tk, input logic [31:0] off);
        wait_req();
        @(negedge clk);
        for (int d = 0; d < dly; d++) begin
            chk("wait_no_valid", 32'(instr_valid), 32'd0);
            chk("wait_no_req", 32'(imem_req), 32'd0);
            @(negedge clk);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = e.w;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        chk_fields(e);
        for (int s = 0; s < stall_cyc; s++) begin
            branch_taken  = 1'b1;
            branch_offset = $urandom;
            imem_rvalid   = 1'b1;
            imem_rdata    = ~e.w;
            @(negedge clk);
            chk("stall_no_req", 32'(imem_req), 32'd0);
            chk_fields(e);
        end
        imem_rvalid   = 1'b0;
        stall         = 1'b0;
        branch_taken  = tk;
        branch_offset = off;
        @(negedge clk);
        stall        = 1'b1;
        branch_taken = 1'b0;
        mpc = tk ? mpc + off : mpc + 32'd4;
        chk("req_after_release", 32'(imem_req), 32'd1);
        chk("valid_dropped", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //         word          tipo  f3    f7     rd     rs1    rs2    imm           ill
        tbl[0]  = '{32'h002081B3, 3'd3, 3'd0, 7'h00, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0};
        tbl[1]  = '{32'hFFC12283, 3'd0, 3'd2, 7'h7F, 5'd5,  5'd2,  5'd28, 32'hFFFFFFFC, 1'b0};
        tbl[2]  = '{32'h00512423, 3'd2, 3'd2, 7'h00, 5'd8,  5'd2,  5'd5,  32'h00000008, 1'b0};
        tbl[3]  = '{32'hFE512E23, 3'd2, 3'd2, 7'h7F, 5'd28, 5'd2,  5'd5,  32'hFFFFFFFC, 1'b0};
        tbl[4]  = '{32'h00208463, 3'd6, 3'd0, 7'h00, 5'd8,  5'd1,  5'd2,  32'h00000008, 1'b0};
        tbl[5]  = '{32'hFE2088E3, 3'd6, 3'd0, 7'h7F, 5'd17, 5'd1,  5'd2,  32'hFFFFFFF0, 1'b0};
        tbl[6]  = '{32'hFFF00093, 3'd1, 3'd0, 7'h7F, 5'd1,  5'd0,  5'd31, 32'hFFFFFFFF, 1'b0};
        tbl[7]  = '{32'h00000043, 3'd4, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
        tbl[8]  = '{32'h00000012, 3'd1, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
        tbl[9]  = '{32'h0000007F, 3'd7, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
        tbl[10] = '{32'h00000000, 3'd0, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};

        reset = 1'b1; stall = 1'b1; branch_taken = 1'b0; branch_offset = '0;
        imem_rvalid = 1'b0; imem_rdata = '0; mpc = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_imm", imm, 32'h0);
        chk("rst_fields", {tipo, funct3, funct7, rd, rs1, rs2}, 32'h0);

        reset = 1'b0;
        #1 chk("idle_no_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("req_after_idle", 32'(imem_req), 32'd1);

        // R-type at 0, lw at 4, then sw at 8 with slow response, stall, stray rvalid, branch.
        do_fetch(tbl[0], 0, 0, 1'b0, 32'h0);
        do_fetch(tbl[1], 0, 0, 1'b0, 32'h0);
        do_fetch(tbl[2], 5, 3, 1'b1, 32'h10);
        chk("branch_target", mpc, 32'h18);
        for (int i = 3; i < 11; i++)
            do_fetch(tbl[i], $urandom_range(0, 2), $urandom_range(0, 1), 1'b0, 32'h0);

        // Random fetches with random latency, stall length and redirects (wrap included).
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
            do_fetch(model(w), $urandom_range(0, 3), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), $urandom);
        end

        // Reset in the middle of WAIT, followed by a late response.
        wait_req();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_imm", imm, 32'h0);
        chk("midrst_fields", {tipo, funct3, funct7, rd, rs1, rs2}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        mpc = 32'h0;
        chk("late_rsp_valid", 32'(instr_valid), 32'd0);
        chk("late_rsp_rd", 32'(rd), 32'd0);
        chk("late_rsp_imm", imm, 32'h0);

        // All-zero word: flagged illegal, still issued, PC steps by 4.
        do_fetch(tbl[10], 0, 0, 1'b0, 32'h0);
        wait_req();
        chk("illegal_pc_step", imem_addr, 32'h4);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
